// File: rtl/lc3_ctrl_pkg.sv
// Shared types and encodings for the LC-3 control sequencer.
package lc3_ctrl_pkg;

  typedef enum logic [4:0] {
    ST_HALTED, ST_S18, ST_S33, ST_S35, ST_PAUSE1, ST_PAUSE2, ST_S32,
    ST_S01, ST_S05, ST_S09, ST_S00, ST_S22, ST_S12, ST_S04, ST_S21,
    ST_S06, ST_S07, ST_S25, ST_S27, ST_S23, ST_S16, ST_SP1, ST_SP2
  } state_t;

  localparam logic [3:0] OP_BR    = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_JSR   = 4'b0100;
  localparam logic [3:0] OP_AND   = 4'b0101;
  localparam logic [3:0] OP_LDR   = 4'b0110;
  localparam logic [3:0] OP_STR   = 4'b0111;
  localparam logic [3:0] OP_NOT   = 4'b1001;
  localparam logic [3:0] OP_JMP   = 4'b1100;
  localparam logic [3:0] OP_PAUSE = 4'b1101;

  localparam logic [1:0] PCMUX_BUS  = 2'b00;
  localparam logic [1:0] PCMUX_ADDR = 2'b01;
  localparam logic [1:0] PCMUX_INC  = 2'b10;

  localparam logic [1:0] ADDR2_ZERO  = 2'b00;
  localparam logic [1:0] ADDR2_OFF6  = 2'b01;
  localparam logic [1:0] ADDR2_OFF9  = 2'b10;
  localparam logic [1:0] ADDR2_OFF11 = 2'b11;

  localparam logic [1:0] ALUK_ADD   = 2'b00;
  localparam logic [1:0] ALUK_AND   = 2'b01;
  localparam logic [1:0] ALUK_NOT   = 2'b10;
  localparam logic [1:0] ALUK_PASSA = 2'b11;

  // States that hold an SRAM strobe for MEM_WAIT cycles.
  function automatic logic is_mem_state(state_t s);
    return (s == ST_S33) || (s == ST_S25) || (s == ST_S16);
  endfunction

endpackage

// File: rtl/lc3_ctrl_fsm_if.sv
// IR/BEN inputs and datapath/SRAM control outputs of the LC-3 sequencer.
interface lc3_ctrl_fsm_if;
  logic       Run, Continue;
  logic [3:0] Opcode;
  logic       IR_5, IR_11, BEN;
  logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
  logic       GatePC, GateMDR, GateALU, GateMARMUX;
  logic       MIO_EN;
  logic [1:0] PCMUX;
  logic       DRMUX, SR1MUX, SR2MUX, ADDR1MUX;
  logic [1:0] ADDR2MUX, ALUK;
  logic       Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE;

  modport master (
    input  Run, Continue, Opcode, IR_5, IR_11, BEN,
    output LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
    output GatePC, GateMDR, GateALU, GateMARMUX, MIO_EN,
    output PCMUX, DRMUX, SR1MUX, SR2MUX, ADDR1MUX, ADDR2MUX, ALUK,
    output Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE
  );

  modport slave (
    output Run, Continue, Opcode, IR_5, IR_11, BEN,
    input  LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
    input  GatePC, GateMDR, GateALU, GateMARMUX, MIO_EN,
    input  PCMUX, DRMUX, SR1MUX, SR2MUX, ADDR1MUX, ADDR2MUX, ALUK,
    input  Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE
  );
endinterface

// File: rtl/lc3_ctrl_fsm_mem_wait_ctr.sv
// SRAM strobe length counter: cleared on entry to an access state,
// done on the MEM_WAIT-th cycle of that state.
module mem_wait_ctr #(
  parameter int MEM_WAIT = 2
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic start,
  input  logic busy,
  output logic done
);
  localparam int            W    = $clog2(MEM_WAIT + 1);
  localparam logic [W-1:0]  LAST = W'(MEM_WAIT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge Clk) begin
    if (!Reset_n)
      cnt <= '0;
    else if (start)
      cnt <= '0;
    else if (busy && !done)
      cnt <= cnt + W'(1);
  end

  assign done = busy && (cnt == LAST);

endmodule

// File: rtl/lc3_ctrl_fsm.sv
// LC-3 control sequencer: fetch, decode and nine-opcode execute, with
// parametrised SRAM access length and optional post-fetch pause.
//  state        | meaning
//  HALTED       | idle after reset, waits for Run
//  S18/S33/S35  | fetch: MAR<-PC, SRAM read, IR<-MDR
//  PAUSE1/2     | Continue high-then-low after fetch (PAUSE_FETCH=1)
//  S32          | decode, load BEN
//  S01/S05/S09  | ADD / AND / NOT
//  S00/S22      | BR test / BR taken
//  S12, S04/S21 | JMP, JSR (save PC to R7, then jump)
//  S06/S25/S27  | LDR: address, SRAM read, register write
//  S07/S23/S16  | STR: address, MDR<-SR, SRAM write
//  SP1/SP2      | LED pause, Continue high-then-low
module lc3_ctrl_fsm
  import lc3_ctrl_pkg::*;
#(
  parameter int MEM_WAIT    = 2,
  parameter int PAUSE_FETCH = 0
) (
  input logic            Clk,
  input logic            Reset_n,
  lc3_ctrl_fsm_if.master bus
);

  state_t state, state_next;
  logic   wait_start, wait_busy, wait_done;

  assign wait_busy  = is_mem_state(state);
  assign wait_start = is_mem_state(state_next) && (state_next != state);

  mem_wait_ctr #(.MEM_WAIT(MEM_WAIT)) u_wait (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .start   (wait_start),
    .busy    (wait_busy),
    .done    (wait_done)
  );

  always_ff @(posedge Clk) begin
    if (!Reset_n)
      state <= ST_HALTED;
    else
      state <= state_next;
  end

  assign bus.Mem_CE = 1'b0;
  assign bus.Mem_UB = 1'b0;
  assign bus.Mem_LB = 1'b0;

  always_comb begin
    state_next     = state;
    bus.LD_MAR     = 1'b0;
    bus.LD_MDR     = 1'b0;
    bus.LD_IR      = 1'b0;
    bus.LD_BEN     = 1'b0;
    bus.LD_CC      = 1'b0;
    bus.LD_REG     = 1'b0;
    bus.LD_PC      = 1'b0;
    bus.LD_LED     = 1'b0;
    bus.GatePC     = 1'b0;
    bus.GateMDR    = 1'b0;
    bus.GateALU    = 1'b0;
    bus.GateMARMUX = 1'b0;
    bus.MIO_EN     = 1'b0;
    bus.PCMUX      = PCMUX_BUS;
    bus.DRMUX      = 1'b0;
    bus.SR1MUX     = 1'b0;
    bus.SR2MUX     = 1'b0;
    bus.ADDR1MUX   = 1'b0;
    bus.ADDR2MUX   = ADDR2_ZERO;
    bus.ALUK       = ALUK_ADD;
    bus.Mem_OE     = 1'b1;
    bus.Mem_WE     = 1'b1;

    case (state)
      ST_HALTED: if (bus.Run) state_next = ST_S18;
      ST_S18: begin
        bus.GatePC = 1'b1;
        bus.LD_MAR = 1'b1;
        bus.PCMUX  = PCMUX_INC;
        bus.LD_PC  = 1'b1;
        state_next = ST_S33;
      end
      ST_S33, ST_S25: begin
        bus.Mem_OE = 1'b0;
        bus.MIO_EN = 1'b1;
        bus.LD_MDR = wait_done;
        if (wait_done) state_next = (state == ST_S33) ? ST_S35 : ST_S27;
      end
      ST_S35: begin
        bus.GateMDR = 1'b1;
        bus.LD_IR   = 1'b1;
        state_next  = (PAUSE_FETCH != 0) ? ST_PAUSE1 : ST_S32;
      end
      ST_PAUSE1: if (bus.Continue)  state_next = ST_PAUSE2;
      ST_PAUSE2: if (!bus.Continue) state_next = ST_S32;
      ST_S32: begin
        bus.LD_BEN = 1'b1;
        case (bus.Opcode)
          OP_ADD:   state_next = ST_S01;
          OP_AND:   state_next = ST_S05;
          OP_NOT:   state_next = ST_S09;
          OP_BR:    state_next = ST_S00;
          OP_JMP:   state_next = ST_S12;
          OP_JSR:   state_next = ST_S04;
          OP_LDR:   state_next = ST_S06;
          OP_STR:   state_next = ST_S07;
          OP_PAUSE: state_next = ST_SP1;
          default:  state_next = ST_S18;
        endcase
      end
      ST_S01, ST_S05, ST_S09: begin
        bus.GateALU = 1'b1;
        bus.LD_REG  = 1'b1;
        bus.LD_CC   = 1'b1;
        bus.SR2MUX  = (state == ST_S09) ? 1'b0 : bus.IR_5;
        bus.ALUK    = (state == ST_S01) ? ALUK_ADD :
                      (state == ST_S05) ? ALUK_AND : ALUK_NOT;
        state_next  = ST_S18;
      end
      ST_S00: state_next = bus.BEN ? ST_S22 : ST_S18;
      ST_S22: begin
        bus.ADDR2MUX = ADDR2_OFF9;
        bus.PCMUX    = PCMUX_ADDR;
        bus.LD_PC    = 1'b1;
        state_next   = ST_S18;
      end
      ST_S12: begin
        bus.ADDR1MUX = 1'b1;
        bus.PCMUX    = PCMUX_ADDR;
        bus.LD_PC    = 1'b1;
        state_next   = ST_S18;
      end
      ST_S04: begin
        bus.GatePC = 1'b1;
        bus.DRMUX  = 1'b1;
        bus.LD_REG = 1'b1;
        state_next = ST_S21;
      end
      // JSR uses a PC-relative offset, JSRR the base register.
      ST_S21: begin
        bus.LD_PC    = 1'b1;
        bus.PCMUX    = PCMUX_ADDR;
        bus.ADDR1MUX = !bus.IR_11;
        bus.ADDR2MUX = bus.IR_11 ? ADDR2_OFF11 : ADDR2_ZERO;
        state_next   = ST_S18;
      end
      ST_S06, ST_S07: begin
        bus.GateMARMUX = 1'b1;
        bus.LD_MAR     = 1'b1;
        bus.ADDR1MUX   = 1'b1;
        bus.ADDR2MUX   = ADDR2_OFF6;
        state_next     = (state == ST_S06) ? ST_S25 : ST_S23;
      end
      ST_S27: begin
        bus.GateMDR = 1'b1;
        bus.LD_REG  = 1'b1;
        bus.LD_CC   = 1'b1;
        state_next  = ST_S18;
      end
      ST_S23: begin
        bus.SR1MUX  = 1'b1;
        bus.ALUK    = ALUK_PASSA;
        bus.GateALU = 1'b1;
        bus.LD_MDR  = 1'b1;
        state_next  = ST_S16;
      end
      ST_S16: begin
        bus.Mem_WE = 1'b0;
        if (wait_done) state_next = ST_S18;
      end
      ST_SP1: begin
        bus.LD_LED = 1'b1;
        if (bus.Continue) state_next = ST_SP2;
      end
      ST_SP2: begin
        bus.LD_LED = 1'b1;
        if (!bus.Continue) state_next = ST_S18;
      end
      default: state_next = ST_HALTED;
    endcase
  end

endmodule

// File: tb/tb_lc3_ctrl_fsm.sv
// Bench for lc3_ctrl_fsm: three parameterisations checked cycle by cycle
// against a per-opcode micro-step model with randomised side inputs.
module tb_lc3_ctrl_fsm;

  typedef struct packed {
    logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
    logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
    logic       mio_en;
    logic [1:0] pcmux;
    logic       drmux, sr1mux, sr2mux, addr1mux;
    logic [1:0] addr2mux, aluk;
    logic       ce, ub, lb, oe, we;
  } ctl_t;

  typedef struct packed {
    ctl_t c;
    logic cont;
  } step_t;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       run = 1'b0, cont = 1'b0, ir5 = 1'b0, ir11 = 1'b0, ben = 1'b0;
  logic [3:0] opcode = 4'b0000;
  int         sel = 0;
  int         checks = 0, passed = 0;
  ctl_t       obs_all [3];
  ctl_t       obs;
  step_t      exp_q[$];

  always #5 Clk = ~Clk;

  lc3_ctrl_fsm_if bus_a ();
  lc3_ctrl_fsm_if bus_b ();
  lc3_ctrl_fsm_if bus_c ();

  assign {bus_a.Run, bus_a.Continue, bus_a.Opcode, bus_a.IR_5, bus_a.IR_11, bus_a.BEN} = {run, cont, opcode, ir5, ir11, ben};
  assign {bus_b.Run, bus_b.Continue, bus_b.Opcode, bus_b.IR_5, bus_b.IR_11, bus_b.BEN} = {run, cont, opcode, ir5, ir11, ben};
  assign {bus_c.Run, bus_c.Continue, bus_c.Opcode, bus_c.IR_5, bus_c.IR_11, bus_c.BEN} = {run, cont, opcode, ir5, ir11, ben};

  lc3_ctrl_fsm #(.MEM_WAIT(2), .PAUSE_FETCH(0)) u_dut_a (.Clk(Clk), .Reset_n(Reset_n), .bus(bus_a));
  lc3_ctrl_fsm #(.MEM_WAIT(3), .PAUSE_FETCH(0)) u_dut_b (.Clk(Clk), .Reset_n(Reset_n), .bus(bus_b));
  lc3_ctrl_fsm #(.MEM_WAIT(1), .PAUSE_FETCH(1)) u_dut_c (.Clk(Clk), .Reset_n(Reset_n), .bus(bus_c));

  always_comb begin
    obs_all[0] = {bus_a.LD_MAR, bus_a.LD_MDR, bus_a.LD_IR, bus_a.LD_BEN, bus_a.LD_CC, bus_a.LD_REG, bus_a.LD_PC, bus_a.LD_LED,
                  bus_a.GatePC, bus_a.GateMDR, bus_a.GateALU, bus_a.GateMARMUX, bus_a.MIO_EN, bus_a.PCMUX,
                  bus_a.DRMUX, bus_a.SR1MUX, bus_a.SR2MUX, bus_a.ADDR1MUX, bus_a.ADDR2MUX, bus_a.ALUK,
                  bus_a.Mem_CE, bus_a.Mem_UB, bus_a.Mem_LB, bus_a.Mem_OE, bus_a.Mem_WE};
    obs_all[1] = {bus_b.LD_MAR, bus_b.LD_MDR, bus_b.LD_IR, bus_b.LD_BEN, bus_b.LD_CC, bus_b.LD_REG, bus_b.LD_PC, bus_b.LD_LED,
                  bus_b.GatePC, bus_b.GateMDR, bus_b.GateALU, bus_b.GateMARMUX, bus_b.MIO_EN, bus_b.PCMUX,
                  bus_b.DRMUX, bus_b.SR1MUX, bus_b.SR2MUX, bus_b.ADDR1MUX, bus_b.ADDR2MUX, bus_b.ALUK,
                  bus_b.Mem_CE, bus_b.Mem_UB, bus_b.Mem_LB, bus_b.Mem_OE, bus_b.Mem_WE};
    obs_all[2] = {bus_c.LD_MAR, bus_c.LD_MDR, bus_c.LD_IR, bus_c.LD_BEN, bus_c.LD_CC, bus_c.LD_REG, bus_c.LD_PC, bus_c.LD_LED,
                  bus_c.GatePC, bus_c.GateMDR, bus_c.GateALU, bus_c.GateMARMUX, bus_c.MIO_EN, bus_c.PCMUX,
                  bus_c.DRMUX, bus_c.SR1MUX, bus_c.SR2MUX, bus_c.ADDR1MUX, bus_c.ADDR2MUX, bus_c.ALUK,
                  bus_c.Mem_CE, bus_c.Mem_UB, bus_c.Mem_LB, bus_c.Mem_OE, bus_c.Mem_WE};
    obs = obs_all[sel];
  end

  function automatic int mw_of(int s);
    return (s == 0) ? 2 : (s == 1) ? 3 : 1;
  endfunction

  function automatic ctl_t dflt();
    ctl_t c;
    c    = '0;
    c.oe = 1'b1;
    c.we = 1'b1;
    return c;
  endfunction

  function automatic ctl_t fetch_vec();
    ctl_t c;
    c = dflt();
    c.gate_pc = 1'b1; c.ld_mar = 1'b1; c.pcmux = 2'b10; c.ld_pc = 1'b1;
    return c;
  endfunction

  task automatic push(input ctl_t c, input logic k);
    step_t s;
    s.c    = c;
    s.cont = k;
    exp_q.push_back(s);
  endtask

  task automatic push_free(input ctl_t c);
    push(c, 1'($urandom_range(0, 1)));
  endtask

  // Continue stays low a random while, goes high a random while, then drops.
  task automatic push_hs(input ctl_t c);
    int k, m;
    k = $urandom_range(1, 3);
    for (int j = 0; j < k; j++) push(c, j == k - 1);
    m = $urandom_range(1, 3);
    for (int j = 0; j < m; j++) push(c, j != m - 1);
  endtask

  task automatic push_mem(input int mw, input bit rd);
    ctl_t c;
    for (int i = 0; i < mw; i++) begin
      c = dflt();
      if (rd) begin
        c.oe = 1'b0; c.mio_en = 1'b1; c.ld_mdr = (i == mw - 1);
      end else begin
        c.we = 1'b0;
      end
      push_free(c);
    end
  endtask

  // Expected per-cycle outputs from one S18 entry up to (not incl.) the next.
  task automatic model(input logic [3:0] op, input logic i5, input logic i11, input logic b);
    ctl_t c;
    int   mw;
    mw = mw_of(sel);
    exp_q.delete();
    push_free(fetch_vec());
    push_mem(mw, 1'b1);
    c = dflt(); c.gate_mdr = 1'b1; c.ld_ir = 1'b1; push_free(c);
    if (sel == 2) push_hs(dflt());
    c = dflt(); c.ld_ben = 1'b1; push_free(c);
    case (op)
      4'b0001, 4'b0101, 4'b1001: begin
        c = dflt(); c.gate_alu = 1'b1; c.ld_reg = 1'b1; c.ld_cc = 1'b1;
        c.sr2mux = (op == 4'b1001) ? 1'b0 : i5;
        c.aluk   = (op == 4'b0001) ? 2'b00 : (op == 4'b0101) ? 2'b01 : 2'b10;
        push_free(c);
      end
      4'b0000: begin
        push_free(dflt());
        if (b) begin
          c = dflt(); c.pcmux = 2'b01; c.addr2mux = 2'b10; c.ld_pc = 1'b1; push_free(c);
        end
      end
      4'b1100: begin
        c = dflt(); c.addr1mux = 1'b1; c.pcmux = 2'b01; c.ld_pc = 1'b1; push_free(c);
      end
      4'b0100: begin
        c = dflt(); c.gate_pc = 1'b1; c.drmux = 1'b1; c.ld_reg = 1'b1; push_free(c);
        c = dflt(); c.ld_pc = 1'b1; c.pcmux = 2'b01;
        if (i11) c.addr2mux = 2'b11; else c.addr1mux = 1'b1;
        push_free(c);
      end
      4'b0110, 4'b0111: begin
        c = dflt(); c.gate_marmux = 1'b1; c.ld_mar = 1'b1; c.addr1mux = 1'b1; c.addr2mux = 2'b01;
        push_free(c);
        if (op == 4'b0110) begin
          push_mem(mw, 1'b1);
          c = dflt(); c.gate_mdr = 1'b1; c.ld_reg = 1'b1; c.ld_cc = 1'b1; push_free(c);
        end else begin
          c = dflt(); c.sr1mux = 1'b1; c.aluk = 2'b11; c.gate_alu = 1'b1; c.ld_mdr = 1'b1;
          push_free(c);
          push_mem(mw, 1'b0);
        end
      end
      4'b1101: begin
        c = dflt(); c.ld_led = 1'b1; push_hs(c);
      end
      default: ;
    endcase
  endtask

  // Precondition: #1 after the edge that entered S18.
  task automatic run_instr(input logic [3:0] op, input logic i5, input logic i11, input logic b, input string tag);
    opcode = op; ir5 = i5; ir11 = i11; ben = b;
    model(op, i5, i11, b);
    foreach (exp_q[i]) begin
      checks++;
      if (obs !== exp_q[i].c)
        $display("FAIL %s dut=%0d op=%b step %0d: got %h expected %h", tag, sel, op, i, obs, exp_q[i].c);
      else
        passed++;
      cont = exp_q[i].cont;
      run  = 1'($urandom_range(0, 1));
      @(posedge Clk); #1;
    end
  endtask

  task automatic check_fetch(input string tag);
    checks++;
    if (obs !== fetch_vec())
      $display("FAIL %s dut=%0d: got %h expected fetch %h", tag, sel, obs, fetch_vec());
    else
      passed++;
  endtask

  task automatic check_idle_all(input string tag);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (obs_all[d] !== dflt())
        $display("FAIL %s dut=%0d: got %h expected idle %h", tag, d, obs_all[d], dflt());
      else
        passed++;
    end
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    run     = 1'b1;
    cont    = 1'($urandom_range(0, 1));
    @(posedge Clk); #1;
    check_idle_all("reset_run_low");
    Reset_n = 1'b1;
    run     = 1'b0;
    repeat (2) begin
      cont = 1'($urandom_range(0, 1));
      @(posedge Clk); #1;
    end
    check_idle_all("halted_no_run");
  endtask

  task automatic start();
    run = 1'b1;
    @(posedge Clk); #1;
    run = 1'b0;
  endtask

  task automatic test_reset();
    sel = 0;
    do_reset();
    start();
    check_fetch("run_to_s18");
  endtask

  task automatic test_add_timing();
    sel = 0;
    do_reset();
    start();
    run_instr(4'b0001, 1'b1, 1'b0, 1'b0, "add_mw2");
    check_fetch("add_mw2_next");
  endtask

  task automatic test_alu();
    logic [3:0] ops [3];
    ops[0] = 4'b0001; ops[1] = 4'b0101; ops[2] = 4'b1001;
    sel = 1;
    do_reset();
    start();
    repeat (6)
      run_instr(ops[$urandom_range(0, 2)], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "alu");
    check_fetch("alu_next");
  endtask

  task automatic test_branch();
    sel = 0;
    do_reset();
    start();
    run_instr(4'b0000, 1'b0, 1'b0, 1'b0, "br_not_taken");
    run_instr(4'b0000, 1'b1, 1'b1, 1'b1, "br_taken");
    run_instr(4'b0000, 1'b0, 1'b1, 1'b0, "br_not_taken2");
    check_fetch("br_next");
  endtask

  task automatic test_jmp_jsr();
    sel = 1;
    do_reset();
    start();
    run_instr(4'b1100, 1'b0, 1'b0, 1'b0, "jmp");
    run_instr(4'b0100, 1'b0, 1'b1, 1'b0, "jsr");
    run_instr(4'b0100, 1'b1, 1'b0, 1'b1, "jsrr");
    check_fetch("jsr_next");
  endtask

  task automatic test_ldr_str();
    sel = 1;
    do_reset();
    start();
    run_instr(4'b0110, 1'b0, 1'b0, 1'b0, "ldr");
    run_instr(4'b0111, 1'b1, 1'b0, 1'b0, "str");
    run_instr(4'b0110, 1'b1, 1'b1, 1'b1, "ldr2");
    check_fetch("ldst_next");
  endtask

  task automatic test_pause();
    sel = 2;
    do_reset();
    start();
    run_instr(4'b1101, 1'b0, 1'b0, 1'b0, "led_pause");
    run_instr(4'b0001, 1'b1, 1'b0, 1'b0, "pause_add");
    run_instr(4'b0111, 1'b0, 1'b0, 1'b0, "pause_str_mw1");
    run_instr(4'b0110, 1'b0, 1'b0, 1'b0, "pause_ldr_mw1");
    check_fetch("pause_next");
  endtask

  task automatic test_reset_mid_access();
    ctl_t c;
    sel = 1;
    do_reset();
    start();
    @(posedge Clk); #1;
    c = dflt(); c.oe = 1'b0; c.mio_en = 1'b1;
    checks++;
    if (obs !== c) $display("FAIL mid_s33: got %h expected %h", obs, c); else passed++;
    Reset_n = 1'b0;
    @(posedge Clk); #1;
    checks++;
    if (obs !== dflt()) $display("FAIL mid_reset_release: got %h expected %h", obs, dflt()); else passed++;
    Reset_n = 1'b1;
    @(posedge Clk); #1;
    checks++;
    if (obs !== dflt()) $display("FAIL mid_reset_halted: got %h expected %h", obs, dflt()); else passed++;
    start();
    run_instr(4'b0110, 1'b0, 1'b0, 1'b0, "after_mid_reset");
    check_fetch("after_mid_reset_next");
  endtask

  task automatic test_back_to_back();
    for (int s = 0; s < 3; s++) begin
      sel = s;
      do_reset();
      start();
      repeat (20)
        run_instr(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "b2b");
      check_fetch("b2b_next");
    end
  endtask

  initial begin
    test_reset();
    test_add_timing();
    test_alu();
    test_branch();
    test_jmp_jsr();
    test_ldr_str();
    test_pause();
    test_reset_mid_access();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
